dmem_lsu_port: RTL and testbench

Initiator side of the CPU data-memory port: takes load/store ops from the pipeline, drives the `dmem_req_*` / `dmem_resp_*` interface, and returns results. The memory is word-addressed, has no byte enables, and answers loads a fixed time after the request. Sub-word stores are therefore done as read-modify-write, and sub-word loads are extracted and extended here. One op is in flight at a time, and a response timeout turns a hung memory into a reported error.

---
 rtl/dmem_lsu_port.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_lsu_port.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_port.sv
// Load/store initiator for a word-addressed data memory without byte enables.
// Sub-word stores use read-modify-write; sub-word loads are extracted and extended here.
//
// state    | meaning
// IDLE     | ready for a new op
// LD_REQ   | load read request offered, waiting for dmem_req_ready
// LD_WAIT  | waiting for load response (timed)
// RMW_REQ  | sub-word store read request offered
// RMW_WAIT | waiting for read data to merge into (timed)
// ST_REQ   | write request offered (full or merged word)
// DONE     | ld_valid or st_done pulse
// ERR      | err_valid pulse
module dmem_lsu_port #(
  parameter int TAG_W        = 4,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_is_store,
  input  logic [1:0]       op_size,
  input  logic             op_unsigned,
  input  logic [31:0]      op_addr,
  input  logic [31:0]      op_wdata,
  input  logic [TAG_W-1:0] op_tag,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_req_we,
  output logic [31:0]      dmem_req_addr,
  output logic [31:0]      dmem_req_data,
  input  logic             dmem_resp_valid,
  input  logic [31:0]      dmem_resp_data,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic             st_done,
  output logic [TAG_W-1:0] res_tag,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, RMW_REQ, RMW_WAIT, ST_REQ, DONE, ERR
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         a_lane;
  logic [1:0]         a_size;
  logic               a_uns;
  logic [15:0]        a_wdata;
  logic [TAG_W-1:0]   a_tag;

  logic               op_bad_size, op_misalign, timed_out;
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [31:0]        ld_ext, merged;

  assign op_bad_size = (op_size == 2'd3);
  assign op_misalign = (op_size == 2'd1 && op_addr[0]) ||
                       (op_size == 2'd2 && op_addr[1:0] != 2'b00);
  assign timed_out   = (cnt == CNT_LAST);

  always_comb begin
    lane_byte = dmem_resp_data[7:0];
    case (a_lane)
      2'd1:    lane_byte = dmem_resp_data[15:8];
      2'd2:    lane_byte = dmem_resp_data[23:16];
      2'd3:    lane_byte = dmem_resp_data[31:24];
      default: lane_byte = dmem_resp_data[7:0];
    endcase
    lane_half = a_lane[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];

    case (a_size)
      2'd0:    ld_ext = a_uns ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'd1:    ld_ext = a_uns ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: ld_ext = dmem_resp_data;
    endcase

    // only byte/half stores ever reach the merge
    merged = dmem_resp_data;
    if (a_size == 2'd0) begin
      case (a_lane)
        2'd1:    merged[15:8]  = a_wdata[7:0];
        2'd2:    merged[23:16] = a_wdata[7:0];
        2'd3:    merged[31:24] = a_wdata[7:0];
        default: merged[7:0]   = a_wdata[7:0];
      endcase
    end else if (a_lane[1]) begin
      merged[31:16] = a_wdata;
    end else begin
      merged[15:0] = a_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      a_lane         <= '0;
      a_size         <= '0;
      a_uns          <= 1'b0;
      a_wdata        <= '0;
      a_tag          <= '0;
      op_ready       <= 1'b1;
      busy           <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_data  <= '0;
      ld_valid       <= 1'b0;
      ld_data        <= '0;
      st_done        <= 1'b0;
      res_tag        <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
    end else begin
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
      res_tag   <= '0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            a_lane        <= op_addr[1:0];
            a_size        <= op_size;
            a_uns         <= op_unsigned;
            a_wdata       <= op_wdata[15:0];
            a_tag         <= op_tag;
            op_ready      <= 1'b0;
            busy          <= 1'b1;
            dmem_req_addr <= {op_addr[31:2], 2'b00};
            if (op_bad_size || op_misalign) begin
              state     <= ERR;
              err_valid <= 1'b1;
              err_code  <= op_bad_size ? 2'd3 : 2'd1;
              res_tag   <= op_tag;
            end else if (!op_is_store) begin
              state          <= LD_REQ;
              dmem_req_valid <= 1'b1;
            end else if (op_size == 2'd2) begin
              state          <= ST_REQ;
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= 1'b1;
              dmem_req_data  <= op_wdata;
            end else begin
              state          <= RMW_REQ;
              dmem_req_valid <= 1'b1;
            end
          end
        end
        LD_REQ, RMW_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            cnt            <= '0;
            state          <= (state == LD_REQ) ? LD_WAIT : RMW_WAIT;
          end
        end
        LD_WAIT, RMW_WAIT: begin
          // a response in the limit cycle still completes normally
          if (dmem_resp_valid) begin
            if (state == LD_WAIT) begin
              state    <= DONE;
              ld_valid <= 1'b1;
              ld_data  <= ld_ext;
              res_tag  <= a_tag;
            end else begin
              state          <= ST_REQ;
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= 1'b1;
              dmem_req_data  <= merged;
            end
          end else if (timed_out) begin
            state     <= ERR;
            err_valid <= 1'b1;
            err_code  <= 2'd2;
            res_tag   <= a_tag;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            state          <= DONE;
            st_done        <= 1'b1;
            res_tag        <= a_tag;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Bench for dmem_lsu_port: directed latency/corner cases then random ops against a
// word-array memory model; results and memory requests are checked against queues.
module tb_dmem_lsu_port;
  localparam int TAG_W = 4;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0, op_ready, op_is_store = 1'b0, op_unsigned = 1'b0;
  logic [1:0]       op_size = 2'd0;
  logic [31:0]      op_addr = '0, op_wdata = '0;
  logic [TAG_W-1:0] op_tag = '0;
  logic             dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0]      dmem_req_addr, dmem_req_data;
  logic             dmem_resp_valid;
  logic [31:0]      dmem_resp_data;
  logic             ld_valid, st_done, err_valid, busy;
  logic [31:0]      ld_data;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       err_code;

  dmem_lsu_port #(.TAG_W(TAG_W), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_tag(op_tag),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_data(dmem_req_data), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .st_done(st_done), .res_tag(res_tag),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // memory seen by the DUT and the model's own view of it
  logic [31:0] dmem [logic [29:0]];
  logic [31:0] mmem [logic [29:0]];

  typedef struct { int kind; logic [TAG_W-1:0] tag; logic [31:0] data; } res_t;  // 0 ld,1 st,2 err
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } req_t;
  res_t rq[$];
  req_t qq[$];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mmem.exists(a[31:2])) return mmem[a[31:2]];
    return 32'd0;
  endfunction

  function automatic logic [31:0] drd(input logic [31:0] a);
    if (dmem.exists(a[31:2])) return dmem[a[31:2]];
    return 32'd0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    dmem[a[31:2]] = v;
    mmem[a[31:2]] = v;
  endtask

  // ---------------- result compare process ----------------
  int pulses = 0, pulse_cyc = 0;
  logic [31:0] pulse_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      int np;
      np = int'(ld_valid) + int'(st_done) + int'(err_valid);
      if (np > 0) begin
        res_t e;
        pulses++;
        pulse_cyc  = cyc;
        pulse_data = err_valid ? {30'd0, err_code} : ld_data;
        chk("one_pulse", np, 1);
        if (rq.size() == 0) chk("unexpected_pulse", {29'd0, ld_valid, st_done, err_valid}, 0);
        else begin
          e = rq.pop_front();
          chk("res_tag", {28'd0, res_tag}, {28'd0, e.tag});
          case (e.kind)
            0: begin chk("ld_valid", {31'd0, ld_valid}, 1); chk("ld_data", ld_data, e.data); end
            1: chk("st_done", {31'd0, st_done}, 1);
            default: begin
              chk("err_valid", {31'd0, err_valid}, 1);
              chk("err_code", {30'd0, err_code}, e.data);
            end
          endcase
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  bit no_resp = 0, ready_rand = 0, delay_rand = 0, stray = 0;
  int stall_left = 0, stall_bad = 0, req_vis = 0;
  bit stall_ref = 0;
  logic [31:0] sr_addr, sr_data;
  logic sr_we;
  bit pending = 0;
  int pend_cnt = 0;
  logic [31:0] pend_data = '0;

  initial begin
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
    forever begin
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = $urandom;
      if (pending) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pending = 0;
          if (!no_resp) begin dmem_resp_valid = 1'b1; dmem_resp_data = pend_data; end
        end
      end
      if (stray) dmem_resp_valid = 1'b1;
      dmem_req_ready = (stall_left > 0) ? 1'b0 :
                       ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (rst_n && dmem_req_valid) begin
        req_vis++;
        if (!dmem_req_ready) begin
          if (stall_left > 0) begin
            if (!stall_ref) begin
              stall_ref = 1; sr_addr = dmem_req_addr; sr_data = dmem_req_data; sr_we = dmem_req_we;
            end else if (sr_addr !== dmem_req_addr || sr_data !== dmem_req_data || sr_we !== dmem_req_we)
              stall_bad++;
            stall_left--;
          end
        end else if (qq.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          req_t e;
          e = qq.pop_front();
          chk("req_we", {31'd0, dmem_req_we}, {31'd0, e.we});
          chk("req_addr", dmem_req_addr, e.addr);
          if (dmem_req_we) begin
            chk("req_data", dmem_req_data, e.data);
            dmem[dmem_req_addr[31:2]] = dmem_req_data;
          end else begin
            pending   = 1;
            pend_cnt  = delay_rand ? int'($urandom_range(1, 4)) : 2;
            pend_data = drd(dmem_req_addr);
          end
        end
      end
    end
  end

  // ---------------- op driving ----------------
  task automatic issue(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TAG_W-1:0] tg, output int acc);
    @(posedge clk); #1;
    op_valid = 1'b1; op_is_store = st; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = wd; op_tag = tg;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    chk("op_accepted", {31'd0, op_ready}, 1);
    acc = cyc;
    @(posedge clk); #1;
    op_valid = 1'b0; op_addr = $urandom; op_wdata = $urandom; op_is_store = $urandom_range(0, 1);
  endtask

  task automatic wait_res(input int acc, output int lat, output logic [31:0] d);
    int p0;
    p0 = pulses;
    for (int n = 0; n < 300 && pulses == p0; n++) begin @(negedge clk); #1; end
    chk("result_seen", pulses - p0, 1);
    lat = pulse_cyc - acc;
    d   = pulse_data;
  endtask

  task automatic do_op(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TAG_W-1:0] tg, input bit exp_to,
                       output int lat, output logic [31:0] d);
    int acc, sh;
    logic [31:0] w, v, mask, al;
    al = {a[31:2], 2'b00};
    sh = 8 * int'(a[1:0]);
    w  = mrd(a);
    if (sz == 2'd3)                                      rq.push_back('{2, tg, 32'd3});
    else if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0))
                                                         rq.push_back('{2, tg, 32'd1});
    else if (!st) begin
      qq.push_back('{1'b0, al, 32'd0});
      if (sz == 2'd2) v = w;
      else begin
        v = (w >> sh) & ((sz == 2'd0) ? 32'hFF : 32'hFFFF);
        if (!uns && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFFFF00;
        if (!uns && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      if (exp_to) rq.push_back('{2, tg, 32'd2});
      else        rq.push_back('{0, tg, v});
    end else begin
      if (sz == 2'd2) v = wd;
      else begin
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        v = (w & ~mask) | ((wd << sh) & mask);
        qq.push_back('{1'b0, al, 32'd0});
      end
      qq.push_back('{1'b1, al, v});
      mmem[a[31:2]] = v;
      rq.push_back('{1, tg, 32'd0});
    end
    issue(st, sz, uns, a, wd, tg, acc);
    wait_res(acc, lat, d);
  endtask

  initial begin
    int lat, acc, p0, v0;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_op_ready", {31'd0, op_ready}, 1);
    chk("rst_outputs_zero", {31'd0, |{dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
        ld_valid, ld_data, st_done, res_tag, err_valid, err_code, busy}}, 0);
    @(negedge clk); rst_n = 1'b1;

    // store then load a word
    do_op(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 4'd3, 0, lat, d);
    chk("sw_latency", lat, 2);
    do_op(0, 2'd2, 0, 32'h100, 32'h0, 4'd5, 0, lat, d);
    chk("lw_latency", lat, 4);
    chk("lw_data_lit", d, 32'hDEADBEEF);

    // byte store by read-modify-write
    preload(32'h200, 32'h11223344);
    do_op(1, 2'd0, 0, 32'h202, 32'h000000AA, 4'd6, 0, lat, d);
    chk("sb_latency", lat, 5);
    chk("sb_mem_lit", drd(32'h200), 32'h11AA3344);

    // sub-word load extension
    preload(32'h300, 32'h80FF7F01);
    do_op(0, 2'd0, 0, 32'h301, 0, 4'd1, 0, lat, d); chk("lb_301", d, 32'h0000007F);
    do_op(0, 2'd0, 0, 32'h302, 0, 4'd2, 0, lat, d); chk("lb_302", d, 32'hFFFFFFFF);
    do_op(0, 2'd0, 1, 32'h303, 0, 4'd3, 0, lat, d); chk("lbu_303", d, 32'h00000080);
    do_op(0, 2'd1, 0, 32'h302, 0, 4'd4, 0, lat, d); chk("lh_302", d, 32'hFFFF80FF);

    // access errors: no memory traffic, op_ready returns right after the pulse
    v0 = req_vis;
    do_op(0, 2'd2, 0, 32'h105, 0, 4'd7, 0, lat, d);
    chk("err_lw_code", d, 1); chk("err_lw_latency", lat, 1);
    @(negedge clk); chk("err_lw_ready_back", {31'd0, op_ready}, 1);
    do_op(1, 2'd1, 0, 32'h101, 32'h1234, 4'd8, 0, lat, d);
    chk("err_sh_code", d, 1);
    @(negedge clk); chk("err_sh_ready_back", {31'd0, op_ready}, 1);
    do_op(0, 2'd3, 0, 32'h100, 0, 4'd9, 0, lat, d);
    chk("err_size_code", d, 3);
    @(negedge clk); chk("err_size_ready_back", {31'd0, op_ready}, 1);
    chk("err_no_req", req_vis - v0, 0);

    // response timeout, then a late response while idle
    no_resp = 1;
    do_op(0, 2'd2, 0, 32'h100, 0, 4'd10, 1, lat, d);
    chk("timeout_latency", lat, 2 + TO);
    chk("timeout_code", d, 2);
    p0 = pulses;
    @(posedge clk); #1; stray = 1;
    repeat (3) @(posedge clk);
    #1; stray = 0; no_resp = 0;
    repeat (3) @(negedge clk);
    chk("late_resp_ignored", pulses - p0, 0);

    // write request held off for 5 cycles
    stall_left = 5; stall_ref = 0; stall_bad = 0;
    do_op(1, 2'd2, 0, 32'h140, 32'h12345678, 4'd11, 0, lat, d);
    chk("stall_latency", lat, 7);
    chk("stall_stable", stall_bad, 0);
    chk("stall_consumed", stall_left, 0);

    // reset while waiting for RMW read data
    no_resp = 1;
    p0 = pulses;
    qq.push_back('{1'b0, 32'h204, 32'd0});
    issue(1, 2'd0, 0, 32'h205, 32'h55, 4'd12, acc);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b0; #1;
    chk("midrst_op_ready", {31'd0, op_ready}, 1);
    chk("midrst_outputs_zero", {31'd0, |{dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
        ld_valid, ld_data, st_done, res_tag, err_valid, err_code, busy}}, 0);
    chk("midrst_read_issued", 32'(qq.size()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    no_resp = 0;
    chk("midrst_no_pulse", pulses - p0, 0);

    // randomized ops
    for (int i = 0; i < 16; i++) preload(32'h400 + 32'(4 * i), $urandom);
    ready_rand = 1; delay_rand = 1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      logic [31:0] a;
      int r;
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      a  = 32'h400 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_op($urandom_range(0, 1), sz, $urandom_range(0, 1), a, $urandom, 4'($urandom), 0, lat, d);
    end
    repeat (4) @(negedge clk);
    chk("queues_drained", 32'(rq.size() + qq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
